// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, FSM states,
// source identifiers, header byte values and a byte-padding helper.
// Optional feature macro: UART_TX_ARB_HDR_EN (adds the HDR state and header bytes).
package uart_arb_pkg;

  localparam int UART_WIDTH = 8;

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd2
  } arb_state_t;
`endif

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [7:0] HDR_BYTE_A = 8'h01;
  localparam logic [7:0] HDR_BYTE_B = 8'h02;

  // Number of whole bytes needed to carry a word of the given bit width.
  function automatic int pad_bytes(input int width);
    return (width + UART_WIDTH - 32'sd1) / UART_WIDTH;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Left-aligned shift register that presents the most significant unsent byte
// of a loaded word and drops one byte per shift, with a remaining-byte counter.
module word_serializer
  import uart_arb_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load,
  input  logic [W-1:0]          load_data,
  input  logic [CW-1:0]         load_cnt,
  input  logic                  shift,
  output logic [UART_WIDTH-1:0] byte_out,
  output logic                  last
);

  logic [W-1:0]  shreg_r;
  logic [CW-1:0] cnt_r;

  // Load a new word or shift out the byte that was just handed over.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      shreg_r <= load_data;
      cnt_r   <= load_cnt;
    end else if (shift && (cnt_r != '0)) begin
      shreg_r <= shreg_r << UART_WIDTH;
      cnt_r   <= cnt_r - CW'(1);
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  assign byte_out = shreg_r[W-1 -: UART_WIDTH];
  assign last     = (cnt_r == CW'(1));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter between two AXI-Stream word sources feeding a byte-wide
// UART transmit stream. Words are sent MSB byte first and never interleaved.
// Optional feature macro: UART_TX_ARB_HDR_EN (one source-ID header byte per word).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [A_WIDTH-1:0] a_axis_tdata,
  input  logic               a_axis_tvalid,
  output logic               a_axis_tready,
  input  logic [B_WIDTH-1:0] b_axis_tdata,
  input  logic               b_axis_tvalid,
  output logic               b_axis_tready,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic               grant_id
);

  localparam int NA_BYTES  = pad_bytes(A_WIDTH);
  localparam int NB_BYTES  = pad_bytes(B_WIDTH);
  localparam int NA        = NA_BYTES * UART_WIDTH;
  localparam int NB        = NB_BYTES * UART_WIDTH;
  localparam int NMAX      = (NA > NB) ? NA : NB;
  localparam int MAX_BYTES = NMAX / UART_WIDTH;
  localparam int CW        = $clog2(MAX_BYTES) + 1;

  arb_state_t      state_r;
  logic            grant_r;
  logic            last_grant_r;
  logic            m_tvalid_r;
  logic            busy_r;
  logic            idle_s;
  logic            grant_a_s;
  logic            grant_b_s;
  logic            accept_s;
  logic            shift_s;
  logic [NMAX-1:0] a_ext_s;
  logic [NMAX-1:0] b_ext_s;
  logic [NMAX-1:0] load_data_s;
  logic [CW-1:0]   load_cnt_s;
  logic [7:0]      ser_byte_s;
  logic            ser_last_s;
`ifdef UART_TX_ARB_HDR_EN
  logic [7:0]      hdr_r;
`endif

  // A source wins alone, or on a tie when the other one was served last.
  assign idle_s    = (state_r == ST_IDLE);
  assign grant_a_s = idle_s && a_axis_tvalid && (!b_axis_tvalid || (last_grant_r == SRC_B));
  assign grant_b_s = idle_s && b_axis_tvalid && (!a_axis_tvalid || (last_grant_r == SRC_A));
  assign accept_s  = grant_a_s || grant_b_s;
  assign shift_s   = (state_r == ST_DATA) && m_axis_tready;

  assign a_axis_tready = grant_a_s;
  assign b_axis_tready = grant_b_s;

  // Zero-extend the granted word and left-align it so its top byte goes first.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    a_ext_s[A_WIDTH-1:0] = a_axis_tdata;
    b_ext_s[B_WIDTH-1:0] = b_axis_tdata;
    if (grant_b_s) begin
      load_data_s = b_ext_s << (NMAX - NB);
      load_cnt_s  = CW'(NB_BYTES);
    end else begin
      load_data_s = a_ext_s << (NMAX - NA);
      load_cnt_s  = CW'(NA_BYTES);
    end
  end

  word_serializer #(
    .W  (NMAX),
    .CW (CW)
  ) u_ser (
    .clk       (clk),
    .arst      (arst),
    .load      (accept_s),
    .load_data (load_data_s),
    .load_cnt  (load_cnt_s),
    .shift     (shift_s),
    .byte_out  (ser_byte_s),
    .last      (ser_last_s)
  );

  // Arbitration FSM: accept in IDLE, optionally send a header, then the word bytes.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r      <= ST_IDLE;
      m_tvalid_r   <= 1'b0;
      busy_r       <= 1'b0;
      grant_r      <= SRC_A;
      last_grant_r <= SRC_B;
`ifdef UART_TX_ARB_HDR_EN
      hdr_r        <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            grant_r      <= grant_b_s ? SRC_B : SRC_A;
            last_grant_r <= grant_b_s ? SRC_B : SRC_A;
            m_tvalid_r   <= 1'b1;
            busy_r       <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
            hdr_r        <= grant_b_s ? HDR_BYTE_B : HDR_BYTE_A;
            state_r      <= ST_HDR;
`else
            state_r      <= ST_DATA;
`endif
          end
        end
`ifdef UART_TX_ARB_HDR_EN
        ST_HDR: begin
          if (m_axis_tready) begin
            state_r <= ST_DATA;
          end
        end
`endif
        ST_DATA: begin
          if (m_axis_tready && ser_last_s) begin
            state_r    <= ST_IDLE;
            m_tvalid_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          m_tvalid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_ARB_HDR_EN
  assign m_axis_tdata = (state_r == ST_HDR) ? hdr_r : ser_byte_s;
`else
  assign m_axis_tdata = ser_byte_s;
`endif
  assign m_axis_tvalid = m_tvalid_r;
  assign busy          = busy_r;
  assign grant_id      = grant_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized
// run checked against a word-level round-robin reference model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic [15:0] a_data;
  logic        a_valid, a_ready;
  logic [7:0]  b_data;
  logic        b_valid, b_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_ready;
  logic        busy, grant_id;

  logic [11:0] a12_data;
  logic        a12_valid, a12_ready;
  logic [7:0]  b12_data;
  logic        b12_valid, b12_ready;
  logic [7:0]  m12_data;
  logic        m12_valid, m12_ready;
  logic        busy12, grant12;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] bw_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.A_WIDTH(16), .B_WIDTH(8)) dut (
    .clk(clk), .arst(arst),
    .a_axis_tdata(a_data), .a_axis_tvalid(a_valid), .a_axis_tready(a_ready),
    .b_axis_tdata(b_data), .b_axis_tvalid(b_valid), .b_axis_tready(b_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.A_WIDTH(12), .B_WIDTH(8)) dut12 (
    .clk(clk), .arst(arst),
    .a_axis_tdata(a12_data), .a_axis_tvalid(a12_valid), .a_axis_tready(a12_ready),
    .b_axis_tdata(b12_data), .b_axis_tvalid(b12_valid), .b_axis_tready(b12_ready),
    .m_axis_tdata(m12_data), .m_axis_tvalid(m12_valid), .m_axis_tready(m12_ready),
    .busy(busy12), .grant_id(grant12)
  );

  // Reference: bytes a word must produce on the wire (optional header, then MSB first).
  function automatic void push_word(input logic [31:0] w, input int width, input bit src);
`ifdef UART_TX_ARB_HDR_EN
    exp_q.push_back(src ? 8'h02 : 8'h01);
`endif
    for (int i = (width + 7) / 8 - 1; i >= 0; i--) begin
      exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
    end
  endfunction

  // Reference: both sources always pending -> A first, then alternate; leftovers in order.
  function automatic void build_expected();
    int ia = 0;
    int ib = 0;
    bit turn_a = 1'b1;
    exp_q.delete();
    while (ia < aw_q.size() || ib < bw_q.size()) begin
      if (ia < aw_q.size() && (turn_a || ib >= bw_q.size())) begin
        push_word(aw_q[ia], 16, 1'b0);
        ia++;
        turn_a = 1'b0;
      end else begin
        push_word(bw_q[ib], 8, 1'b1);
        ib++;
        turn_a = 1'b1;
      end
    end
  endfunction

  task automatic apply_reset();
    arst = 1'b1;
    a_valid = 1'b0; a_data = 16'h0000;
    b_valid = 1'b0; b_data = 8'h00;
    m_ready = 1'b0;
    a12_valid = 1'b0; a12_data = 12'h000;
    b12_valid = 1'b0; b12_data = 8'h00;
    m12_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b0;
    #3;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", grant_id); end
    apply_reset();
    a_valid = 1'b1; a_data = 16'h1111;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_single();
    int pulses = 0;
    apply_reset();
    exp_q.delete();
    push_word(32'hBEEF, 16, 1'b0);
    a_valid = 1'b1; a_data = 16'hBEEF; m_ready = 1'b1;
    for (int k = 0; k <= exp_q.size() + 1; k++) begin
      @(negedge clk);
      if (a_ready) pulses++;
      if (k == 0) begin
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", a_ready); end
      end else if (k <= exp_q.size()) begin
        checks++; if (m_valid !== 1'b1 || m_data !== exp_q[k-1] || busy !== 1'b1) begin
          errors++; $display("FAIL single_byte%0d got v=%b d=%h busy=%b want v=1 d=%h busy=1", k, m_valid, m_data, busy, exp_q[k-1]);
        end
      end else begin
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL single_end got v=%b busy=%b want 0 0", m_valid, busy);
        end
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_tready_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_tie();
    apply_reset();
    aw_q.delete(); bw_q.delete(); obs_q.delete();
    aw_q.push_back(32'h1234); bw_q.push_back(32'h5A);
    build_expected();
    a_valid = 1'b1; a_data = 16'h1234;
    b_valid = 1'b1; b_data = 8'h5A;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      logic acc_a, acc_b;
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      if (m_valid && m_ready) obs_q.push_back(m_data);
      @(posedge clk); #1;
      if (acc_a) a_valid = 1'b0;
      if (acc_b) b_valid = 1'b0;
    end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tie_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL tie_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_stall();
    int nstall = 0;
    int nchk = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;
    logic acc;
    apply_reset();
    exp_q.delete(); obs_q.delete();
    push_word(32'hA55A, 16, 1'b0);
    a_valid = 1'b1; a_data = 16'hA55A; m_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      acc = a_valid && a_ready;
      if (pv && !pr) begin
        nchk++;
        checks++; if (m_valid !== 1'b1 || m_data !== pd) begin
          errors++; $display("FAIL stall_hold got v=%b d=%h want v=1 d=%h", m_valid, m_data, pd);
        end
      end
      if (m_valid && m_ready) obs_q.push_back(m_data);
      pv = m_valid; pr = m_ready; pd = m_data;
      @(posedge clk); #1;
      if (acc) a_valid = 1'b0;
      if (obs_q.size() == 1 && nstall < 10) begin m_ready = 1'b0; nstall++; end
      else m_ready = 1'b1;
    end
    checks++; if (nchk != 10) begin errors++; $display("FAIL stall_cycles got %0d want 10", nchk); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_atomic();
    int a_bytes = 0;
    bit a_acc = 1'b0, b_acc = 1'b0;
    logic acc;
    apply_reset();
    exp_q.delete();
    push_word(32'h3C3C, 16, 1'b0);
    a_valid = 1'b1; a_data = 16'h3C3C; m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !b_acc; cyc++) begin
      @(negedge clk);
      acc = a_valid && a_ready;
      if (b_valid && b_ready) begin
        b_acc = 1'b1;
        checks++; if (a_bytes != exp_q.size()) begin
          errors++; $display("FAIL atomic_grant_b after %0d A bytes want %0d", a_bytes, exp_q.size());
        end
      end else if (b_valid) begin
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL atomic_b_ready got %b want 0", b_ready); end
      end
      if (m_valid && m_ready) a_bytes++;
      @(posedge clk); #1;
      if (acc) begin a_valid = 1'b0; a_acc = 1'b1; b_valid = 1'b1; b_data = 8'hC3; end
      m_ready = 1'($urandom_range(0, 1));
    end
    checks++; if (!b_acc) begin errors++; $display("FAIL atomic_timeout got b_acc=0 want 1"); end
    b_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nbytes = 0;
    logic acc;
    apply_reset();
    a_valid = 1'b1; a_data = 16'hCAFE; m_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && nbytes == 0; cyc++) begin
      @(negedge clk);
      acc = a_valid && a_ready;
      if (m_valid && m_ready) nbytes++;
      @(posedge clk); #1;
      if (acc) a_valid = 1'b0;
    end
    #1 arst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 8'h00) begin
      errors++; $display("FAIL midreset got v=%b busy=%b d=%h want 0 0 00", m_valid, busy, m_data);
    end
    @(negedge clk);
    arst = 1'b0;
    nbytes = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid) nbytes++;
    end
    checks++; if (nbytes != 0) begin errors++; $display("FAIL midreset_resend got %0d bytes want 0", nbytes); end
  endtask

  task automatic test_random();
    int ia = 0, ib = 0;
    bit done = 1'b0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;
    apply_reset();
    aw_q.delete(); bw_q.delete(); obs_q.delete();
    repeat ($urandom_range(1, 5)) aw_q.push_back(32'($urandom_range(0, 65535)));
    repeat ($urandom_range(1, 5)) bw_q.push_back(32'($urandom_range(0, 255)));
    build_expected();
    a_valid = 1'b1; a_data = 16'(aw_q[0]);
    b_valid = 1'b1; b_data = 8'(bw_q[0]);
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      if (pv && !pr) begin
        checks++; if (m_valid !== 1'b1 || m_data !== pd) begin
          errors++; $display("FAIL rand_hold got v=%b d=%h want v=1 d=%h", m_valid, m_data, pd);
        end
      end
      if (a_ready && b_ready) begin errors++; $display("FAIL rand_dual_ready got 1 1 want one"); end
      if (m_valid && m_ready) obs_q.push_back(m_data);
      if (a_valid && a_ready) ia++;
      if (b_valid && b_ready) ib++;
      pv = m_valid; pr = m_ready; pd = m_data;
      @(posedge clk); #1;
      a_valid = (ia < aw_q.size());
      if (a_valid) a_data = 16'(aw_q[ia]);
      b_valid = (ib < bw_q.size());
      if (b_valid) b_data = 8'(bw_q[ib]);
      m_ready = ($urandom_range(0, 3) != 0);
      done = !a_valid && !b_valid && !busy;
    end
    checks++; if (!done) begin errors++; $display("FAIL rand_timeout got done=0 want 1"); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_width12();
    logic acc;
    apply_reset();
    exp_q.delete(); obs_q.delete();
    push_word(32'hABC, 12, 1'b0);
    a12_valid = 1'b1; a12_data = 12'hABC; m12_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      acc = a12_valid && a12_ready;
      if (m12_valid && m12_ready) obs_q.push_back(m12_data);
      @(posedge clk); #1;
      if (acc) a12_valid = 1'b0;
    end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL w12_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL w12_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_atomic();
    test_reset_mid();
    repeat (4) test_random();
    test_width12();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, giving the bit width of source A words (processor output).
REQ-002 SHALL have parameter B_WIDTH, default 8, giving the bit width of source B words (status/error reports).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports a_axis_tdata  input  A_WIDTH, a_axis_tvalid  input  1, a_axis_tready  output  1, forming the source A AXI-Stream slave.
REQ-006 SHALL have ports b_axis_tdata  input  B_WIDTH, b_axis_tvalid  input  1, b_axis_tready  output  1, forming the source B AXI-Stream slave.
REQ-007 SHALL have ports m_axis_tdata  output  8, m_axis_tvalid  output  1, m_axis_tready  input  1, forming the byte master toward the UART transmitter.
REQ-008 SHALL have port busy  output  1, high whenever a word is held or being sent.
REQ-009 SHALL have port grant_id  output  1, where 0 means A and 1 means B; it identifies the source of the word in flight.

Function
REQ-010 SHALL implement the states IDLE, HDR and DATA; HDR SHALL exist only when the macro of REQ-023 is defined.
REQ-011 In IDLE, with exactly one tvalid high, SHALL assert that source's tready combinationally and accept its word that cycle.
REQ-012 In IDLE, with both tvalid high, SHALL grant the source not granted last (round-robin); the other tready SHALL stay 0.
REQ-013 On accept, SHALL latch the word zero-extended to NA=ceil(A_WIDTH/8)*8 or NB=ceil(B_WIDTH/8)*8 bits, load the byte counter, set grant_id, and go to DATA (or HDR).
REQ-014 In DATA, SHALL drive m_axis_tvalid=1 and m_axis_tdata=the most-significant unsent byte (MSB first).
REQ-015 m_axis_tdata/m_axis_tvalid SHALL hold stable until m_axis_tready=1.
REQ-016 Each m-handshake SHALL shift out one byte; the handshake on the last byte SHALL return to IDLE.
REQ-017 Latency: the first byte SHALL be valid the cycle after accept; one IDLE cycle SHALL separate consecutive words.
REQ-018 Words SHALL be atomic: no switch of source mid-word, regardless of the other source's tvalid.
REQ-019 Both trequires SHALL be 0 outside IDLE; busy=(state!=IDLE).
REQ-020 The byte counter width SHALL be $clog2(max byte count)+1; a 1-byte word (width<=8) SHALL be legal.

Reset
REQ-021 On arst assertion, SHALL asynchronously force state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, busy=0, grant_id=0, counter=0, and last-grant=B (so A wins the first tie).
REQ-022 arst mid-word SHALL discard remaining bytes with no partial resend after release.

Configuration
REQ-023 With UART_TX_ARB_HDR_EN defined, SHALL emit one header byte in HDR before DATA: 8'h01 for A, 8'h02 for B, under the same handshake rules; without it, SHALL go IDLE->DATA directly and emit no header.

Structure
REQ-024 Package uart_arb_pkg SHALL hold UART_WIDTH=8, the state enum, the source-ID constants and the header byte values.
REQ-025 The byte shift/count logic SHALL be the sub-module word_serializer, instantiated once at max(NA,NB) width; arbitration/FSM stays in uart_tx_arbiter.

Verification
REQ-026 A=16'hBEEF valid alone, m_tready=1 -> bytes EF? no: BE then EF, on consecutive cycles; a_tready pulses once; busy falls after EF.
REQ-027 A and B valid in the same cycle after reset, A=16'h1234, B=8'h5A -> 12,34 then 5A; with HDR_EN: 01,12,34,02,5A.
REQ-028 m_tready held 0 for 10 cycles mid-word -> m_tdata/m_tvalid stable for all 10 cycles, no byte lost or duplicated.
REQ-029 B asserted during the A word -> b_tready stays 0 until A's last byte, then B is granted.
REQ-030 arst pulsed after the first byte of 16'hCAFE -> m_tvalid=0 immediately; after release, with no valid, no further bytes are emitted.
REQ-031 A_WIDTH=12, A=12'hABC -> bytes 0A, BC.
